// File: rtl/rst_seq_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_pkg
// Purpose  : Shared definitions for the sequenced reset controller:
//            FSM state encoding, index-width helper and default timing.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_HOLD      = 2'd0;
  localparam logic [1:0] ST_RELEASE   = 2'd1;
  localparam logic [1:0] ST_DONE      = 2'd2;
  localparam logic [1:0] ST_SW_ASSERT = 2'd3;

  // Default timing constants
  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_HOLD_CYC    = 129;
  localparam int DEF_STAGE_GAP   = 16;
  localparam int DEF_SW_PULSE    = 8;
  localparam int DEF_SYNC_STAGES = 2;

  // ceil(log2(n)), never less than 1 so a single channel still gets an index bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rst_seq_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_ctl_if
// Purpose  : Control/status bundle of the sequenced reset controller.
// Ports    : ch_en, sw_rst_req (to controller);
//            rstb_out, seq_done, sw_rst_ack (from controller)
//            modport master = user side, slave = controller side
// Revision : 1.0 - initial release
// ============================================================================
interface rst_seq_ctl_if #(
  parameter int NUM_CH = 4
) ();
  logic [NUM_CH-1:0] ch_en;
  logic              sw_rst_req;
  logic [NUM_CH-1:0] rstb_out;
  logic              seq_done;
  logic              sw_rst_ack;

  modport master (
    output ch_en, sw_rst_req,
    input  rstb_out, seq_done, sw_rst_ack
  );

  modport slave (
    input  ch_en, sw_rst_req,
    output rstb_out, seq_done, sw_rst_ack
  );
endinterface

`default_nettype wire

// File: rtl/rst_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : rst_sync_chain
// Purpose  : Async-assert / sync-deassert reset synchroniser.
// Ports    : clk        - clock
//            rstb_in    - asynchronous active-low reset
//            rst_sync_n - synchronised active-low reset (last stage)
// Revision : 1.0 - initial release
// ============================================================================
module rst_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstb_in,
  output logic rst_sync_n
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift a constant 1 in; the chain is cleared as a whole by rstb_in
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rstb_in) begin
    if (!rstb_in) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign rst_sync_n = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rst_seq_ctl.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_ctl
// Purpose  : Synchronises rstb_in, holds reset HOLD_CYC cycles, then releases
//            NUM_CH reset domains in index order STAGE_GAP cycles apart.
//            Supports per-channel enable and software re-reset with ack.
// Ports    : clk     - sole clock
//            rstb_in - asynchronous active-low reset
//            bus     - slave side: ch_en, sw_rst_req in;
//                      rstb_out, seq_done, sw_rst_ack out
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq_ctl
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int STAGE_GAP   = DEF_STAGE_GAP,
  parameter int SW_PULSE    = DEF_SW_PULSE,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          rstb_in,
  rst_seq_ctl_if.slave  bus
);

  localparam int IDX_W = clog2_min1(NUM_CH);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_PULSE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

  // Elaboration-time parameter legality
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("rst_seq_ctl: NUM_CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rst_seq_ctl: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYC < 1 || STAGE_GAP < 1 || SW_PULSE < 1) begin : g_bad_timing
    $error("rst_seq_ctl: HOLD_CYC, STAGE_GAP and SW_PULSE must be >= 1");
  end
  if (HOLD_CYC > (1 << CNT_W) || STAGE_GAP > (1 << CNT_W) ||
      SW_PULSE > (1 << CNT_W)) begin : g_bad_cnt_w
    $error("rst_seq_ctl: CNT_W too narrow for the timing parameters");
  end

  logic rst_sync_n;

  rst_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rstb_in    (rstb_in),
    .rst_sync_n (rst_sync_n)
  );

  logic [1:0]        state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;
  logic [NUM_CH-1:0] rstb_out_q, rstb_out_d;
  logic              seq_done_q, seq_done_d;
  logic              ack_q,      ack_d;
  logic              sw_pend_q,  sw_pend_d;   // sequence was started by software

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rstb_out_d = rstb_out_q;
    seq_done_d = seq_done_q;
    ack_d      = 1'b0;
    sw_pend_d  = sw_pend_q;

    case (state_q)
      ST_HOLD: begin
        if (!rst_sync_n) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        // A disabled channel still consumes its slot, it just stays low
        if (cnt_q == '0) rstb_out_d[idx_q] = bus.ch_en[idx_q];
        if (idx_q == IDX_LAST) begin
          state_d    = ST_DONE;
          seq_done_d = 1'b1;
          cnt_d      = '0;
          ack_d      = sw_pend_q;
          sw_pend_d  = 1'b0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        // Falling enables drop immediately; rising ones wait for a new sequence
        rstb_out_d = rstb_out_q & bus.ch_en;
        if (bus.sw_rst_req) begin
          state_d    = ST_SW_ASSERT;
          rstb_out_d = '0;
          seq_done_d = 1'b0;
          cnt_d      = '0;
        end
      end

      ST_SW_ASSERT: begin
        if (cnt_q == SW_LAST) begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          sw_pend_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rstb_in) begin
    if (!rstb_in) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      rstb_out_q <= '0;
      seq_done_q <= 1'b0;
      ack_q      <= 1'b0;
      sw_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rstb_out_q <= rstb_out_d;
      seq_done_q <= seq_done_d;
      ack_q      <= ack_d;
      sw_pend_q  <= sw_pend_d;
    end
  end

  assign bus.rstb_out   = rstb_out_q;
  assign bus.seq_done   = seq_done_q;
  assign bus.sw_rst_ack = ack_q;

endmodule

`default_nettype wire
